hazard_detection_unit: RTL and testbench
========================================

HAZARD_DETECTION_UNIT -- requirements
Module: hazard_detection_unit

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 1, range 1..7: IF/ID flush length after a taken branch.
REQ-002 SHALL have parameter MEM_TIMEOUT, default 15, range 1..255: freeze cycles before the timeout flag sets.
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 clk_in  in  1  clock; all state updates on the rising edge.
REQ-005 rst_n_in  in  1  asynchronous active-low reset.
REQ-006 IF_ID_RS_in  in  5  rs field of the instruction in ID.
REQ-007 IF_ID_RT_in  in  5  rt field of the instruction in ID.
REQ-008 IF_ID_uses_RT_in  in  1  instruction in ID reads rt as a source.
REQ-009 ID_EX_RT_in  in  5  destination register of the instruction in EX.
REQ-010 ID_EX_mem_read_in  in  1  instruction in EX is a load.
REQ-011 branch_taken_in  in  1  branch resolved taken this cycle.
REQ-012 mem_ready_in  in  1  data memory ready; 0 requests a pipeline freeze.
REQ-013 PC_write_out  out  1  PC write enable.
REQ-014 IF_ID_write_out  out  1  IF/ID write enable.
REQ-015 ID_EX_bubble_out  out  1  zero the ID/EX control fields.
REQ-016 IF_ID_flush_out  out  1  clear IF/ID to a NOP.
REQ-017 mem_timeout_out  out  1  sticky memory-timeout flag.
REQ-018 stall_cycles_out  out  16  saturating count of cycles with PC_write_out=0.

Function
REQ-019 SHALL implement an FSM with states RUN, LOAD_STALL and FLUSH; control outputs are Mealy (combinational from state and inputs).
REQ-020 Load-use hazard SHALL be defined as ID_EX_mem_read_in=1, ID_EX_RT_in!=0, and either ID_EX_RT_in==IF_ID_RS_in or (IF_ID_uses_RT_in=1 and ID_EX_RT_in==IF_ID_RT_in).
REQ-021 Default outputs SHALL be PC_write_out=1, IF_ID_write_out=1, ID_EX_bubble_out=0, IF_ID_flush_out=0.
REQ-022 Priority SHALL be, highest first: freeze (mem_ready_in=0), then branch flush, then load-use.
REQ-023 Freeze behaviour: PC_write_out=0, IF_ID_write_out=0, ID_EX_bubble_out=0, IF_ID_flush_out=0; FSM state and flush counter hold; freeze is valid in every state.
REQ-024 RUN with branch_taken_in=1: IF_ID_flush_out=1 that cycle; next state FLUSH if FLUSH_CYCLES>1, else RUN; flush counter loads FLUSH_CYCLES-1.
REQ-025 RUN with load-use hazard (no branch): PC_write_out=0, IF_ID_write_out=0, ID_EX_bubble_out=1; next state LOAD_STALL.
REQ-026 LOAD_STALL SHALL last one cycle with default outputs and load-use detection masked; if branch_taken_in=1, apply REQ-024 instead; otherwise return to RUN.
REQ-027 FLUSH: IF_ID_flush_out=1, PC_write_out=1; counter decrements each non-frozen cycle; return to RUN when counter reaches 1 on that cycle; branch_taken_in=1 reloads the counter to FLUSH_CYCLES-1.
REQ-028 Flush total SHALL be exactly FLUSH_CYCLES non-frozen cycles with IF_ID_flush_out=1.
REQ-029 8-bit wait counter: increments each frozen cycle and clears on any cycle with mem_ready_in=1.
REQ-030 mem_timeout_out SHALL set when the wait counter reaches MEM_TIMEOUT; it stays 1 until reset, and the freeze continues unchanged.
REQ-031 stall_cycles_out SHALL increment by 1 each cycle PC_write_out=0 and saturate at 16'hFFFF.

Reset
REQ-032 rst_n_in=0 SHALL asynchronously force: state RUN, all counters 0, mem_timeout_out=0, stall_cycles_out=0.
REQ-033 While rst_n_in=0: PC_write_out=0, IF_ID_write_out=0, ID_EX_bubble_out=1, IF_ID_flush_out=0.
REQ-034 Reset asserted mid-FLUSH or mid-freeze SHALL abandon the operation; after release the FSM starts in RUN.

Structure
REQ-035 State encoding (RUN=2'd0, LOAD_STALL=2'd1, FLUSH=2'd2) and the zero-register constant SHALL live in the shared pipeline package.
REQ-036 The saturating stall counter SHALL be a sub-module sat_counter (parameter WIDTH, inputs inc and clear).

Verification
REQ-037 lw into $5 in EX, add reading rs=$5 in ID -> one cycle PC_write_out=0, ID_EX_bubble_out=1, next cycle defaults, stall_cycles_out=1.
REQ-038 Load with rt=$0 and ID rs=$0 -> no stall; stall_cycles_out stays 0.
REQ-039 FLUSH_CYCLES=3, branch_taken_in pulse -> IF_ID_flush_out=1 for exactly 3 cycles; mem_ready_in=0 for 2 cycles mid-flush -> flush stretches to 5 wall-clock cycles.
REQ-040 mem_ready_in=0 for 20 cycles, MEM_TIMEOUT=15 -> mem_timeout_out rises after the 15th frozen cycle and stays 1 after ready returns; stall_cycles_out=20.
REQ-041 Load-use hazard and branch_taken_in in the same cycle -> flush only, PC_write_out=1, no bubble.
REQ-042 rst_n_in pulsed low mid-FLUSH -> outputs take reset values immediately; after release, state RUN and counters 0.

Source files
------------

// File: rtl/hazard_detection_unit_pkg.sv
// Shared pipeline definitions for the hazard detection unit.
// FSM encoding, the zero register and the load-use predicate.
package hazard_detection_unit_pkg;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2
  } hdu_state_e;

  localparam logic [4:0] ZERO_REG = 5'd0;

  function automatic logic load_use(
    input logic       mem_read,
    input logic [4:0] ex_rt,
    input logic [4:0] id_rs,
    input logic [4:0] id_rt,
    input logic       uses_rt
  );
    return mem_read && (ex_rt != ZERO_REG) &&
           ((ex_rt == id_rs) ||
            (uses_rt && (ex_rt == id_rt)));
  endfunction

endpackage

// File: rtl/hazard_detection_unit_if.sv
// Pipeline <-> hazard unit signal bundle.
// master = pipeline side, slave = hazard unit.
interface hazard_detection_unit_if;
  logic [4:0]  IF_ID_RS_in;
  logic [4:0]  IF_ID_RT_in;
  logic        IF_ID_uses_RT_in;
  logic [4:0]  ID_EX_RT_in;
  logic        ID_EX_mem_read_in;
  logic        branch_taken_in;
  logic        mem_ready_in;
  logic        PC_write_out;
  logic        IF_ID_write_out;
  logic        ID_EX_bubble_out;
  logic        IF_ID_flush_out;
  logic        mem_timeout_out;
  logic [15:0] stall_cycles_out;

  modport master (
    output IF_ID_RS_in, IF_ID_RT_in,
    output IF_ID_uses_RT_in, ID_EX_RT_in,
    output ID_EX_mem_read_in,
    output branch_taken_in, mem_ready_in,
    input  PC_write_out, IF_ID_write_out,
    input  ID_EX_bubble_out, IF_ID_flush_out,
    input  mem_timeout_out, stall_cycles_out
  );

  modport slave (
    input  IF_ID_RS_in, IF_ID_RT_in,
    input  IF_ID_uses_RT_in, ID_EX_RT_in,
    input  ID_EX_mem_read_in,
    input  branch_taken_in, mem_ready_in,
    output PC_write_out, IF_ID_write_out,
    output ID_EX_bubble_out, IF_ID_flush_out,
    output mem_timeout_out, stall_cycles_out
  );
endinterface

// File: rtl/hazard_detection_unit_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_count <= '0;
    end else if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use stall, branch flush and memory freeze control.
// Mealy control outputs from a RUN/LOAD_STALL/FLUSH FSM.
module hazard_detection_unit #(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15
) (
  input logic                    clk_in,
  input logic                    rst_n_in,
  hazard_detection_unit_if.slave bus
);
  import hazard_detection_unit_pkg::*;

  localparam logic [2:0] FC_M1 = 3'(FLUSH_CYCLES - 1);
  localparam logic [7:0] TMO   = 8'(MEM_TIMEOUT);

  hdu_state_e r_state;
  hdu_state_e w_state_nxt;
  logic [2:0] r_flush_cnt;
  logic [2:0] w_flush_cnt_nxt;
  logic [7:0] r_wait_cnt;
  logic [7:0] w_wait_inc;
  logic       r_timeout;

  logic w_freeze;
  logic w_branch;
  logic w_hazard;
  logic w_do_freeze;
  logic w_do_flush;
  logic w_do_stall;
  logic w_pc_write;
  logic w_ifid_write;
  logic w_bubble;
  logic w_flush;
  logic w_stall_inc;

  assign w_freeze = ~bus.mem_ready_in;
  assign w_branch = bus.branch_taken_in;
  assign w_hazard = load_use(
    bus.ID_EX_mem_read_in, bus.ID_EX_RT_in,
    bus.IF_ID_RS_in, bus.IF_ID_RT_in,
    bus.IF_ID_uses_RT_in);

  // Mutually exclusive selects encode the priority chain.
  assign w_do_freeze = rst_n_in & w_freeze;
  assign w_do_flush  = rst_n_in & ~w_freeze &
                       (w_branch | (r_state == ST_FLUSH));
  assign w_do_stall  = rst_n_in & ~w_freeze & ~w_branch &
                       (r_state == ST_RUN) & w_hazard;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_flush_cnt <= w_flush_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_flush_cnt_nxt = r_flush_cnt;
    if (!w_freeze) begin
      unique case (r_state)
        ST_RUN, ST_LOAD_STALL: begin
          if (w_branch) begin
            w_state_nxt     = (FLUSH_CYCLES > 1) ?
                              ST_FLUSH : ST_RUN;
            w_flush_cnt_nxt = FC_M1;
          end else if (r_state == ST_RUN && w_hazard) begin
            w_state_nxt = ST_LOAD_STALL;
          end else begin
            w_state_nxt = ST_RUN;
          end
        end
        ST_FLUSH: begin
          if (w_branch) begin
            w_flush_cnt_nxt = FC_M1;
          end else if (r_flush_cnt <= 3'd1) begin
            w_state_nxt     = ST_RUN;
            w_flush_cnt_nxt = 3'd0;
          end else begin
            w_flush_cnt_nxt = r_flush_cnt - 3'd1;
          end
        end
        default: w_state_nxt = ST_RUN;
      endcase
    end
  end

  always_comb begin
    w_pc_write   = 1'b1;
    w_ifid_write = 1'b1;
    w_bubble     = 1'b0;
    w_flush      = 1'b0;
    unique case (1'b1)
      ~rst_n_in: begin
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_bubble     = 1'b1;
      end
      w_do_freeze: begin
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
      end
      w_do_flush: w_flush = 1'b1;
      w_do_stall: begin
        w_pc_write   = 1'b0;
        w_ifid_write = 1'b0;
        w_bubble     = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_wait_inc = r_wait_cnt + 8'd1;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_wait_cnt <= 8'd0;
      r_timeout  <= 1'b0;
    end else if (w_freeze) begin
      if (r_wait_cnt != 8'hFF) r_wait_cnt <= w_wait_inc;
      if (w_wait_inc == TMO) r_timeout <= 1'b1;
    end else begin
      r_wait_cnt <= 8'd0;
    end
  end

  assign w_stall_inc = rst_n_in & ~w_pc_write;

  sat_counter #(.WIDTH(16)) u_stall_cnt (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .inc      (w_stall_inc),
    .clear    (1'b0),
    .count    (bus.stall_cycles_out)
  );

  assign bus.PC_write_out     = w_pc_write;
  assign bus.IF_ID_write_out  = w_ifid_write;
  assign bus.ID_EX_bubble_out = w_bubble;
  assign bus.IF_ID_flush_out  = w_flush;
  assign bus.mem_timeout_out  = r_timeout;

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Scoreboard bench for hazard_detection_unit (FLUSH_CYCLES=3).
// Directed scenarios, random traffic, then stall-counter saturation.
module tb_hazard_detection_unit;

  localparam int FC = 3;
  localparam int MT = 15;

  typedef struct {
    int pc;
    int ifid;
    int bub;
    int fl;
    int tmo;
    int stall;
  } exp_t;

  logic clk_in;
  logic rst_n_in;
  hazard_detection_unit_if bus();

  hazard_detection_unit #(
    .FLUSH_CYCLES (FC),
    .MEM_TIMEOUT  (MT)
  ) dut (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .bus      (bus)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  exp_t q[$];
  int   n_checks = 0;
  int   n_errs   = 0;

  int m_flush_left = 0;
  int m_mask       = 0;
  int m_wait       = 0;
  int m_stall      = 0;
  int m_tmo        = 0;

  task automatic chk(input string nm, input int act,
                     input int req);
    n_checks++;
    if (act != req) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, req, $time);
    end
  endtask

  task automatic step(input bit rst, input bit rdy,
                      input bit br, input bit mr,
                      input bit ur, input logic [4:0] rs,
                      input logic [4:0] rt,
                      input logic [4:0] ex);
    exp_t e;
    bit   hz;
    @(posedge clk_in);
    #1;
    rst_n_in              = rst;
    bus.mem_ready_in      = rdy;
    bus.branch_taken_in   = br;
    bus.ID_EX_mem_read_in = mr;
    bus.IF_ID_uses_RT_in  = ur;
    bus.IF_ID_RS_in       = rs;
    bus.IF_ID_RT_in       = rt;
    bus.ID_EX_RT_in       = ex;
    hz = mr && ex != 0 && (ex == rs || (ur && ex == rt));
    e = '{pc:1, ifid:1, bub:0, fl:0,
          tmo:m_tmo, stall:m_stall};
    if (!rst) begin
      e = '{pc:0, ifid:0, bub:1, fl:0, tmo:0, stall:0};
      m_flush_left = 0;
      m_mask = 0;
      m_wait = 0;
      m_stall = 0;
      m_tmo = 0;
    end else if (!rdy) begin
      e.pc = 0;
      e.ifid = 0;
      m_wait++;
      if (m_wait == MT) m_tmo = 1;
      if (m_stall < 65535) m_stall++;
    end else begin
      m_wait = 0;
      if (br) begin
        e.fl = 1;
        m_flush_left = FC - 1;
        m_mask = 0;
      end else if (m_flush_left > 0) begin
        e.fl = 1;
        m_flush_left--;
        m_mask = 0;
      end else if (hz && !m_mask) begin
        e.pc = 0;
        e.ifid = 0;
        e.bub = 1;
        m_mask = 1;
        if (m_stall < 65535) m_stall++;
      end else begin
        m_mask = 0;
      end
    end
    q.push_back(e);
  endtask

  task automatic idle(input bit rdy);
    step(1, rdy, 0, 0, 0, 5'd0, 5'd0, 5'd0);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_in);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("PC_write", int'(bus.PC_write_out), e.pc);
        chk("IF_ID_write", int'(bus.IF_ID_write_out), e.ifid);
        chk("ID_EX_bubble", int'(bus.ID_EX_bubble_out), e.bub);
        chk("IF_ID_flush", int'(bus.IF_ID_flush_out), e.fl);
        chk("mem_timeout", int'(bus.mem_timeout_out), e.tmo);
        chk("stall_cycles", int'(bus.stall_cycles_out),
            e.stall);
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit hit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n_in              = 1'b0;
    bus.mem_ready_in      = 1'b1;
    bus.branch_taken_in   = 1'b0;
    bus.ID_EX_mem_read_in = 1'b0;
    bus.IF_ID_uses_RT_in  = 1'b0;
    bus.IF_ID_RS_in       = 5'd0;
    bus.IF_ID_RT_in       = 5'd0;
    bus.ID_EX_RT_in       = 5'd0;

    step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    idle(1);

    step(1, 1, 0, 1, 0, 5'd5, 5'd0, 5'd5);
    step(1, 1, 0, 1, 0, 5'd5, 5'd0, 5'd5);
    idle(1);

    step(1, 1, 0, 1, 1, 5'd0, 5'd0, 5'd0);
    step(1, 1, 0, 1, 1, 5'd7, 5'd9, 5'd9);
    step(1, 1, 0, 1, 0, 5'd7, 5'd9, 5'd9);
    idle(1);

    step(1, 1, 1, 1, 0, 5'd6, 5'd0, 5'd6);
    idle(1);
    idle(1);
    idle(1);

    step(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    idle(1);
    idle(0);
    idle(0);
    idle(1);
    idle(1);

    for (int i = 0; i < 20; i++) idle(0);
    idle(1);
    idle(1);

    step(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    idle(1);
    step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    idle(1);
    step(1, 1, 0, 1, 0, 5'd3, 5'd0, 5'd3);
    idle(1);

    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 99) != 0,
           $urandom_range(0, 7) != 0,
           $urandom_range(0, 7) == 0,
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)),
           5'($urandom_range(0, 3)));
    end

    step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 65540; i++) idle(0);
    idle(1);
    step(1, 1, 0, 1, 0, 5'd4, 5'd0, 5'd4);
    idle(1);

    n = 0;
    while (q.size() != 0 && n < 10) begin
      @(negedge clk_in);
      n++;
    end
    @(negedge clk_in);
    if (q.size() != 0) begin
      n_checks++;
      n_errs++;
      $display("FAIL drain: %0d entries left, expected 0",
               q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             n_errs, n_checks);
    $finish;
  end

endmodule
